// File: rtl/alu_defs.sv
// Shared ALU definitions used by the shifter and its issue queue.
// Provides default widths, the shifter op encodings and the request bundle layout.
package alu_defs;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned SHIFT_WIDTH = 5;
  localparam int unsigned OPS         = 2;

  // Shifter op encodings.
  localparam logic [OPS-1:0] LEFT_SHIFTA  = 2'd0;
  localparam logic [OPS-1:0] LEFT_SHIFTL  = 2'd1;
  localparam logic [OPS-1:0] RIGHT_SHIFTA = 2'd2;
  localparam logic [OPS-1:0] RIGHT_SHIFTL = 2'd3;

  // One queued shift request, packed as {data, shift, op}.
  typedef struct packed {
    logic [WIDTH-1:0]       data;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [OPS-1:0]         op;
  } sh_req_t;

  localparam int unsigned REQ_WIDTH = WIDTH + SHIFT_WIDTH + OPS;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with asynchronous active-high reset.
// Storage is cleared on reset so the head reads 0 while empty after reset.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   push, wdata     write strobe and entry; ignored when full
//   pop             read strobe; ignored when empty
//   rdata           current head entry (stale contents when empty)
//   count           number of stored entries, 0..DEPTH
//   full, empty     occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_issue_queue.sv
// Request-buffering front end for the combinational shifter.
// Requests are queued in a FIFO; the head drives the external shifter and its result
// is captured, with the op and an overflow flag, into a valid/ready output register.
// Optional feature: define SHIFT_OVF_EN to build the arithmetic-left overflow flag;
// otherwise out_ovf is tied to 0.
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready              request handshake
//   in_data/in_shift/in_op         request operand, shift amount, op
//   sh_data/sh_shift/sh_op         FIFO head to the shifter inputs
//   sh_result                      shifter result
//   out_valid/out_ready            result handshake
//   out_result/out_op/out_ovf      registered result, its op, overflow flag
module shift_issue_queue #(
  parameter int unsigned WIDTH       = alu_defs::WIDTH,
  parameter int unsigned SHIFT_WIDTH = alu_defs::SHIFT_WIDTH,
  parameter int unsigned OPS         = alu_defs::OPS,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic [OPS-1:0]         in_op,
  output logic [WIDTH-1:0]       sh_data,
  output logic [SHIFT_WIDTH-1:0] sh_shift,
  output logic [OPS-1:0]         sh_op,
  input  logic [WIDTH-1:0]       sh_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [OPS-1:0]         out_op,
  output logic                   out_ovf
);

  import alu_defs::*;

  localparam int unsigned ReqW = WIDTH + SHIFT_WIDTH + OPS;

  logic [ReqW-1:0]          head;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_full, fifo_empty;
  logic                     push, capture;
  logic                     head_ovf;

  logic                     out_valid_q;
  logic [WIDTH-1:0]         out_result_q;
  logic [OPS-1:0]           out_op_q;
  logic                     out_ovf_q;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign capture  = !fifo_empty && (!out_valid_q || out_ready);

  sync_fifo #(
    .WIDTH (ReqW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_data, in_shift, in_op}),
    .pop   (capture),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {sh_data, sh_shift, sh_op} = head;

`ifdef SHIFT_OVF_EN
  // Overflow when any of the top shift+1 bits differs from the sign bit.
  always_comb begin
    head_ovf = 1'b0;
    if (sh_op == OPS'(LEFT_SHIFTA) && sh_shift != '0) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if ((i + int'(sh_shift) >= int'(WIDTH) - 1) && (sh_data[i] != sh_data[WIDTH-1])) begin
          head_ovf = 1'b1;
        end
      end
    end
  end
`else
  assign head_ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
      out_ovf_q    <= 1'b0;
    end else if (capture) begin
      out_valid_q  <= 1'b1;
      out_result_q <= sh_result;
      out_op_q     <= sh_op;
      out_ovf_q    <= head_ovf;
    end else if (out_valid_q && out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_op     = out_op_q;
  assign out_ovf    = out_ovf_q;

  // fifo_count is kept for observability; occupancy decisions use full/empty.
  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_shift_issue_queue.sv
module tb_shift_issue_queue;
  import alu_defs::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SHIFT_WIDTH-1:0] in_shift;
  logic [OPS-1:0]         in_op;
  logic [WIDTH-1:0]       sh_data;
  logic [SHIFT_WIDTH-1:0] sh_shift;
  logic [OPS-1:0]         sh_op;
  logic [WIDTH-1:0]       sh_result;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_result;
  logic [OPS-1:0]         out_op;
  logic                   out_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef SHIFT_OVF_EN
  localparam logic OvfOn = 1'b1;
`else
  localparam logic OvfOn = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_issue_queue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shift   (in_shift),
    .in_op      (in_op),
    .sh_data    (sh_data),
    .sh_shift   (sh_shift),
    .sh_op      (sh_op),
    .sh_result  (sh_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_ovf    (out_ovf)
  );

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [SHIFT_WIDTH-1:0] s,
                                                 input logic [OPS-1:0] op);
    case (op)
      LEFT_SHIFTA, LEFT_SHIFTL: return d << s;
      RIGHT_SHIFTA:             return WIDTH'($signed(d) >>> s);
      default:                  return d >> s;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] d,
                                   input logic [SHIFT_WIDTH-1:0] s,
                                   input logic [OPS-1:0] op);
    logic signed [WIDTH-1:0] t;
    if (!OvfOn || op != LEFT_SHIFTA || s == '0) return 1'b0;
    t = $signed(d) >>> (int'(WIDTH) - 1 - int'(s));
    return !(t == '0 || t == '1);
  endfunction

  // External shifter model.
  always_comb sh_result = ref_shift(sh_data, sh_shift, sh_op);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d,
                       input logic [SHIFT_WIDTH-1:0] s, input logic [OPS-1:0] op);
    in_valid = v;
    in_data  = d;
    in_shift = s;
    in_op    = op;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_valid, out_result, out_op, out_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b r=%h op=%h ovf=%b want all 0",
               out_valid, out_result, out_op, out_ovf);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if ({sh_data, sh_shift, sh_op} !== '0) begin
      n_fail++;
      $display("FAIL reset_sh: got %h/%h/%h want 0", sh_data, sh_shift, sh_op);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0001, 5'd5, LEFT_SHIFTL);
    step();
    drive(1'b0, '0, '0, '0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: out_valid got %b want 0 one cycle after accept", out_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_0020 || out_ovf !== 1'b0 ||
        out_op !== LEFT_SHIFTL) begin
      n_fail++;
      $display("FAIL single_result: got v=%b r=%h op=%h ovf=%b want 1/00000020/%h/0",
               out_valid, out_result, out_op, out_ovf, LEFT_SHIFTL);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 5'd5, RIGHT_SHIFTA);
    step();
    drive(1'b1, 32'h8000_0000, 5'd5, RIGHT_SHIFTL);
    step();
    drive(1'b0, '0, '0, '0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'hFC00_0000 || out_op !== RIGHT_SHIFTA) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b r=%h op=%h want 1/fc000000/%h",
               out_valid, out_result, out_op, RIGHT_SHIFTA);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'h0400_0000 || out_op !== RIGHT_SHIFTL) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b r=%h op=%h want 1/04000000/%h",
               out_valid, out_result, out_op, RIGHT_SHIFTL);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h100 + i, 5'd4, LEFT_SHIFTL);
      if (in_ready) accepted++;
      step();
    end
    drive(1'b0, '0, '0, '0);
    n_cmp++;
    if (accepted != 5 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_capacity: accepted %0d in_ready %b want 5 and 0", accepted, in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b r=%h want 1/00001000", out_valid, out_result);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_comb: in_ready got %b want 0 before pop edge", in_ready);
    end
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_rise: in_ready got %b want 1 after first pop", in_ready);
    end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== (32'h1000 + 32'(i) * 32'h10)) begin
        n_fail++;
        $display("FAIL bp_order%0d: got v=%b r=%h want 1/%h",
                 i, out_valid, out_result, 32'h1000 + 32'(i) * 32'h10);
      end
      step();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_ovf();
    out_ready = 1'b1;
    drive(1'b1, 32'h4000_0000, 5'd1, LEFT_SHIFTA);
    step();
    drive(1'b1, 32'hFFFF_FFF0, 5'd3, LEFT_SHIFTA);
    step();
    drive(1'b0, '0, '0, '0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_ovf !== OvfOn) begin
      n_fail++;
      $display("FAIL ovf_set: got v=%b r=%h ovf=%b want 1/80000000/%b",
               out_valid, out_result, out_ovf, OvfOn);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FF80 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got v=%b r=%h ovf=%b want 1/ffffff80/0",
               out_valid, out_result, out_ovf);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA5A5_0000 + i, 5'd2, RIGHT_SHIFTL);
      step();
    end
    drive(1'b0, '0, '0, '0);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got v=%b in_ready=%b want 1/1", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_result, out_op, out_ovf, sh_data, sh_shift, sh_op} !== '0 ||
        in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_clear: got v=%b r=%h op=%h ovf=%b sh=%h in_ready=%b want 0s/1",
               out_valid, out_result, out_op, out_ovf, sh_data, in_ready);
    end
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    drive(1'b1, 32'h0000_0003, 5'd2, LEFT_SHIFTL);
    step();
    drive(1'b0, '0, '0, '0);
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_000C || out_op !== LEFT_SHIFTL) begin
      n_fail++;
      $display("FAIL rstmid_new: got v=%b r=%h op=%h want 1/0000000c/%h",
               out_valid, out_result, out_op, LEFT_SHIFTL);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale%0d: out_valid got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random();
    sh_req_t q[$];
    sh_req_t e;
    sh_req_t r;
    int sent = 0;
    int recv = 0;
    r = '0;
    for (int cyc = 0; cyc < 1000 && recv < 20; cyc++) begin
      if (sent < 20 && $urandom_range(3) != 0) begin
        r.data  = WIDTH'($urandom());
        r.shift = SHIFT_WIDTH'($urandom());
        r.op    = OPS'($urandom());
        drive(1'b1, r.data, r.shift, r.op);
      end else begin
        drive(1'b0, '0, '0, '0);
      end
      out_ready = ($urandom_range(2) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(r);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: unexpected result r=%h", out_result);
        end else begin
          e = q.pop_front();
          if (out_result !== ref_shift(e.data, e.shift, e.op) || out_op !== e.op ||
              out_ovf !== ref_ovf(e.data, e.shift, e.op)) begin
            n_fail++;
            $display("FAIL rand%0d: got r=%h op=%h ovf=%b want %h/%h/%b", recv,
                     out_result, out_op, out_ovf, ref_shift(e.data, e.shift, e.op), e.op,
                     ref_ovf(e.data, e.shift, e.op));
          end
        end
        recv++;
      end
      step();
    end
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    n_cmp++;
    if (sent != 20 || recv != 20 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: sent %0d recv %0d pending %0d want 20/20/0",
               sent, recv, q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    step();
    step();
    #2;
    rst = 1'b0;
    step();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_ovf();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_issue_queue.md
# shift_issue_queue

Request-buffering front end for the combinational shifter. Accepts shift requests over a valid/ready handshake and queues them in a small FIFO. Drives the FIFO head onto the shifter's data/shift/op inputs and captures the shifter result, plus an optional overflow flag, into an output register with its own valid/ready handshake. Sits between the ALU operand-decode stage and the ALU result writeback.

## Interface
Parameters:
- WIDTH, 32: data width; matches the shifter's `WIDTH`.
- SHIFT_WIDTH, 5: shift-amount width; matches `SHIFT_WIDTH`.
- OPS, 2: op-code width; matches `OPS`.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  queue can accept a request.
- in_data  in  WIDTH  operand.
- in_shift  in  SHIFT_WIDTH  shift amount.
- in_op  in  OPS  `LEFT_SHIFTA`/`LEFT_SHIFTL`/`RIGHT_SHIFTA`/`RIGHT_SHIFTL`.
- sh_data  out  WIDTH  to shifter data input; FIFO-head operand.
- sh_shift  out  SHIFT_WIDTH  to shifter shift input.
- sh_op  out  OPS  to shifter op input.
- sh_result  in  WIDTH  from shifter result.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  registered shifter result.
- out_op  out  OPS  op that produced out_result.
- out_ovf  out  1  arithmetic-left overflow flag.

## Operation
- Push on clk edge when in_valid && in_ready. in_ready = (count < DEPTH); it is purely a function of count and does not depend on pop in the same cycle.
- FIFO storage:
  - Circular buffer; rd_ptr/wr_ptr are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- sh_data/sh_shift/sh_op are driven combinationally from the head entry. When the FIFO is empty they carry the stale head contents, which is harmless.
- Capture condition: count != 0 && (!out_valid || out_ready). On the capture edge:
  - out_result <= sh_result, out_op <= head op, out_ovf <= ovf(head).
  - out_valid <= 1 and pop the head.
- If out_valid && out_ready and the FIFO is empty, out_valid <= 0 and the data registers hold their values.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- out_* hold stable while out_valid && !out_ready.
- Ordering is strictly FIFO; no reordering, no drops.
- Reset (asynchronous, any time, including mid-burst):
  - count, rd_ptr, wr_ptr = 0.
  - out_valid = 0, out_result = 0, out_op = 0, out_ovf = 0.
  - FIFO storage cleared to 0, so sh_data, sh_shift and sh_op all read 0.
  - in_ready = 1.
  - In-flight requests are discarded.

## Timing
- Minimum latency is 2 cycles: accepted at edge N, out_valid high after edge N+1.
- Sustained throughput is 1 request/cycle with out_ready held high.
- Capacity is DEPTH + 1 requests in flight (FIFO plus output register) before in_ready falls.
- in_ready rises the cycle after the first pop from a full FIFO.
- No combinational path from in_* to out_*. Combinational path from the FIFO head through the external shifter to the capture register.

## Configuration
- `SHIFT_OVF_EN` defined:
  - out_ovf = 1 iff op == `LEFT_SHIFTA`, shift != 0, and the top shift+1 bits of data are not all identical, i.e. the sign changes or significant bits are lost.
  - out_ovf = 0 for all other ops and for shift 0.
- `SHIFT_OVF_EN` undefined: out_ovf is tied to 0 and the overflow logic is not built.

## Structure
- Shared package/header `alu_defs`:
  - `WIDTH`, `SHIFT_WIDTH`, `OPS`.
  - Op encodings `LEFT_SHIFTA`, `LEFT_SHIFTL`, `RIGHT_SHIFTA`, `RIGHT_SHIFTL`, taken unchanged from the shifter's definitions.
  - Request struct/bundle width constant.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH), holding the {data, shift, op} entries. Top level contains the capture register, overflow logic and handshake.
- The shifter is instantiated outside this block.

## Test plan
- Single request 32'h8000_0001, shift 5, `LEFT_SHIFTL`, with out_ready=1 → out_valid high 2 cycles after accept, out_result=32'h0000_0020, out_ovf=0.
- Back-to-back stream, one request per cycle:
  - 32'h8000_0000, shift 5, `RIGHT_SHIFTA` → 32'hFC00_0000.
  - 32'h8000_0000, shift 5, `RIGHT_SHIFTL` → 32'h0400_0000.
  - Results are delivered in order on consecutive cycles.
- out_ready=0 and 7 requests offered → exactly 5 accepted, then in_ready=0. Raise out_ready → 5 results in order, and in_ready returns 1 the cycle after the first pop from the full FIFO.
- 32'h4000_0000, shift 1, `LEFT_SHIFTA` → out_result=32'h8000_0000, with out_ovf=1 under `SHIFT_OVF_EN` and out_ovf=0 without it. 32'hFFFF_FFF0, shift 3, `LEFT_SHIFTA` → out_ovf=0.
- Assert rst mid-burst (3 queued, out_valid=1) → all outputs immediately 0 and in_ready=1. After release, a new request completes normally and no pre-reset data appears.
- Wrap-around: 20 random requests with random out_ready stalls → every result matches a reference model, none lost or duplicated.
